// File: rtl/arb_pkg.sv
// Shared constants and helpers for the round-robin / fixed-priority hold arbiter.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/arb_prio_chain.sv
// Combinational daisy-chain priority picker: lowest set index of req wins.
module arb_prio_chain #(
    parameter int N = 8
) (
    input  logic [0:N-1] req,
    output logic [0:N-1] gnt,
    output logic         any
);

    // avail[i] is high while no lower index has claimed the chain
    logic [0:N] avail;

    always_comb begin
        avail[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            gnt[i]       = req[i] & avail[i];
            avail[i + 1] = avail[i] & ~req[i];
        end
        any = ~avail[N];
    end

endmodule

// File: rtl/arbiter_rr_hold_n.sv
// Registered N-way arbiter with fixed/round-robin selection and bounded grant hold.
module arbiter_rr_hold_n
    import arb_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int MAXHOLD = 4,
    localparam int IW      = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          mode,
    input  logic [0:N-1]  r,
    output logic [0:N-1]  g,
    output logic          gvalid,
    output logic [IW-1:0] gid
);

    localparam int              CW        = (MAXHOLD < 1) ? 1 : clog2(MAXHOLD + 1);
    localparam logic [CW-1:0]   CNT_LIMIT = CW'(MAXHOLD);
    localparam logic [CW-1:0]   CNT_MAX   = '1;

    logic [0:N-1]  g_q, g_d;
    logic          gvalid_q, gvalid_d;
    logic [IW-1:0] gid_q, gid_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          holder_req;
    logic          at_limit;
    logic          hold;
    logic          expire;
    logic [0:N-1]  base_req;
    logic [0:N-1]  rr_req;
    logic [0:N-1]  rr_gnt;
    logic          rr_any;
    logic [0:N-1]  all_gnt;
    logic          all_any;
    logic [0:N-1]  win_oh;
    logic [IW-1:0] win_idx;

    assign holder_req = gvalid_q & r[gid_q];
    assign at_limit   = (MAXHOLD != 0) && (cnt_q == CNT_LIMIT);
    assign hold       = holder_req & ~at_limit;
    assign expire     = holder_req & at_limit;

    // An expired holder is excluded so that a waiting requester can take over
    always_comb begin
        base_req = r;
        if (expire) base_req[gid_q] = 1'b0;
        for (int i = 0; i < N; i++) begin
            rr_req[i] = base_req[i] & (i >= int'(ptr_q));
        end
    end

    arb_prio_chain #(.N(N)) u_chain_rr (
        .req (rr_req),
        .gnt (rr_gnt),
        .any (rr_any)
    );

    arb_prio_chain #(.N(N)) u_chain_all (
        .req (base_req),
        .gnt (all_gnt),
        .any (all_any)
    );

    always_comb begin
        win_oh  = ((mode == MODE_RR) && rr_any) ? rr_gnt : all_gnt;
        win_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (win_oh[i]) win_idx = win_idx | IW'(i);
        end
    end

    always_comb begin
        g_d      = g_q;
        gvalid_d = gvalid_q;
        gid_d    = gid_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        if (en) begin
            if (hold) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
            end else if (expire && !all_any) begin
                cnt_d = CW'(1);
            end else if (all_any) begin
                g_d      = win_oh;
                gvalid_d = 1'b1;
                gid_d    = win_idx;
                cnt_d    = CW'(1);
                ptr_d    = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
            end else begin
                g_d      = '0;
                gvalid_d = 1'b0;
                gid_d    = '0;
                cnt_d    = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g_q      <= '0;
            gvalid_q <= 1'b0;
            gid_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            g_q      <= g_d;
            gvalid_q <= gvalid_d;
            gid_q    <= gid_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign g      = g_q;
    assign gvalid = gvalid_q;
    assign gid    = gid_q;

endmodule
